// File: rtl/jump_ctrl.sv
// Jump/call/return control with a circular return-address stack.
// Optional macro JUMP_CTRL_FAULT_EN: sticky fault on stack overflow/underflow.
module jump_ctrl #(
  parameter int PC_COUNT_WIDTH = 6,
  parameter int STACK_DEPTH    = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [PC_COUNT_WIDTH-1:0]        pc_count,
  input  logic                             is_jmp,
  input  logic                             is_jz,
  input  logic                             is_call,
  input  logic                             is_ret,
  input  logic [PC_COUNT_WIDTH-1:0]        target,
  input  logic                             acc_zero,
  output logic                             jump_enable,
  output logic [PC_COUNT_WIDTH-1:0]        jump_value,
  output logic [$clog2(STACK_DEPTH):0]     sp,
  output logic                             stack_empty,
  output logic                             stack_full,
  output logic                             fault
);

  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = PTR_W + 1;

`ifdef JUMP_CTRL_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_JZ   = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;

  logic [PC_COUNT_WIDTH-1:0] stack_mem [STACK_DEPTH];
  // top_ptr is the next free slot modulo depth, so an overflowing push lands on the oldest entry.
  logic [PTR_W-1:0]          top_ptr;
  logic [SP_W-1:0]           sp_q;
  logic                      fault_q;

  logic [2:0]                op;
  logic [PC_COUNT_WIDTH-1:0] top_entry;
  logic [PC_COUNT_WIDTH-1:0] ret_addr;
  logic                      do_push;
  logic                      do_pop;
  logic                      set_fault;

  assign top_entry   = stack_mem[top_ptr - 1'b1];
  assign ret_addr    = pc_count + 1'b1;
  assign stack_empty = (sp_q == '0);
  assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
  assign sp          = sp_q;
  assign fault       = fault_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    op = OP_NONE;
    if (is_ret)       op = OP_RET;
    else if (is_call) op = OP_CALL;
    else if (is_jz)   op = OP_JZ;
    else if (is_jmp)  op = OP_JMP;
  end

  always_comb begin
    jump_enable = 1'b0;
    jump_value  = '0;
    do_push     = 1'b0;
    do_pop      = 1'b0;
    set_fault   = 1'b0;
    case (op)
      OP_RET: begin
        if (!stack_empty) begin
          jump_enable = 1'b1;
          jump_value  = top_entry;
          do_pop      = 1'b1;
        end else begin
          set_fault = FAULT_EN;
        end
      end
      OP_CALL: begin
        jump_value = target;
        if (!stack_full) begin
          jump_enable = 1'b1;
          do_push     = 1'b1;
        end else if (FAULT_EN) begin
          set_fault = 1'b1;
        end else begin
          jump_enable = 1'b1;
          do_push     = 1'b1;
        end
      end
      OP_JZ: begin
        jump_enable = acc_zero;
        jump_value  = target;
      end
      OP_JMP: begin
        jump_enable = 1'b1;
        jump_value  = target;
      end
      default: ;
    endcase
    // A latched fault freezes the stack and suppresses every jump until reset.
    if (fault_q) begin
      jump_enable = 1'b0;
      do_push     = 1'b0;
      do_pop      = 1'b0;
      set_fault   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    if (reset) begin
      // NOTE: stack entries are explicitly cleared on reset, which costs a reset net per bit.
      for (int i = 0; i < STACK_DEPTH; i++) stack_mem[i] <= '0;
      top_ptr <= '0;
      sp_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      if (do_push) begin
        stack_mem[top_ptr] <= ret_addr;
        top_ptr            <= top_ptr + 1'b1;
        if (!stack_full) sp_q <= sp_q + 1'b1;
      end else if (do_pop) begin
        top_ptr <= top_ptr - 1'b1;
        sp_q    <= sp_q - 1'b1;
      end
      if (set_fault) fault_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jump_ctrl.sv
// Scoreboard bench for jump_ctrl: queue-based stack model, directed then random stimulus.
// Honors JUMP_CTRL_FAULT_EN to select the expected error policy.
module tb_jump_ctrl;
  localparam int W = 6;
  localparam int D = 4;

`ifdef JUMP_CTRL_FAULT_EN
  localparam bit FAULT_MODE = 1'b1;
`else
  localparam bit FAULT_MODE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] pc_count, target;
  logic         is_jmp, is_jz, is_call, is_ret, acc_zero;
  logic         jump_enable;
  logic [W-1:0] jump_value;
  logic [2:0]   sp;
  logic         stack_empty, stack_full, fault;

  jump_ctrl #(.PC_COUNT_WIDTH(W), .STACK_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .pc_count(pc_count),
    .is_jmp(is_jmp), .is_jz(is_jz), .is_call(is_call), .is_ret(is_ret),
    .target(target), .acc_zero(acc_zero),
    .jump_enable(jump_enable), .jump_value(jump_value), .sp(sp),
    .stack_empty(stack_empty), .stack_full(stack_full), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic je;
    int   jv;
    bit   chk_jv;
    int   sp;
    logic empty;
    logic full;
    logic flt;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: return addresses in a queue, newest at the back.
  int model_stack[$];
  bit model_fault;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic drive(input bit rst, input bit r, input bit c, input bit z, input bit j,
                       input bit acc, input int pc, input int tgt);
    exp_t e;
    int   n;
    @(posedge clk);
    #1;
    reset = rst; is_ret = r; is_call = c; is_jz = z; is_jmp = j;
    acc_zero = acc; pc_count = W'(pc); target = W'(tgt);

    n = model_stack.size();
    e.je = 1'b0; e.jv = 0; e.chk_jv = 1'b0;
    e.sp = n; e.empty = (n == 0); e.full = (n == D); e.flt = model_fault;
    if (model_fault) e.je = 1'b0;
    else if (r) begin
      if (n > 0) begin e.je = 1'b1; e.jv = model_stack[n-1]; e.chk_jv = 1'b1; end
    end else if (c) begin
      e.je = (n < D) || !FAULT_MODE; e.jv = tgt; e.chk_jv = e.je;
    end else if (z) begin
      e.je = acc; e.jv = tgt; e.chk_jv = acc;
    end else if (j) begin
      e.je = 1'b1; e.jv = tgt; e.chk_jv = 1'b1;
    end else begin
      e.jv = 0; e.chk_jv = 1'b1;
    end
    exp_q.push_back(e);

    if (rst) begin
      model_stack.delete();
      model_fault = 1'b0;
    end else if (!model_fault) begin
      if (r) begin
        if (n > 0) void'(model_stack.pop_back());
        else if (FAULT_MODE) model_fault = 1'b1;
      end else if (c) begin
        if (n < D) model_stack.push_back((pc + 1) % (1 << W));
        else if (FAULT_MODE) model_fault = 1'b1;
        else begin
          void'(model_stack.pop_front());
          model_stack.push_back((pc + 1) % (1 << W));
        end
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("jump_enable", 32'(jump_enable), 32'(e.je));
        if (e.chk_jv) check("jump_value", 32'(jump_value), 32'(e.jv));
        check("sp", 32'(sp), 32'(e.sp));
        check("stack_empty", 32'(stack_empty), 32'(e.empty));
        check("stack_full", 32'(stack_full), 32'(e.full));
        check("fault", 32'(fault), 32'(e.flt));
      end
    end
  end

  initial begin : stimulus
    int u;
    reset = 1'b1; is_ret = 0; is_call = 0; is_jz = 0; is_jmp = 0;
    acc_zero = 0; pc_count = '0; target = '0;
    model_fault = 1'b0;
    repeat (2) @(posedge clk);

    // Directed scenarios (args: rst, ret, call, jz, jmp, acc, pc, target)
    drive(0, 0, 0, 0, 0, 0, 'h00, 'h00);
    drive(0, 0, 0, 0, 1, 0, 'h00, 'h15);
    drive(0, 0, 0, 1, 0, 0, 'h00, 'h08);
    drive(0, 0, 0, 1, 0, 1, 'h00, 'h08);
    drive(0, 0, 1, 0, 0, 0, 'h3F, 'h10);
    drive(0, 1, 0, 0, 0, 0, 'h10, 'h00);
    drive(0, 0, 0, 0, 0, 0, 'h00, 'h00);
    drive(0, 0, 1, 0, 0, 0, 'h01, 'h04);
    drive(0, 0, 1, 0, 0, 0, 'h05, 'h08);
    drive(0, 0, 1, 0, 0, 0, 'h09, 'h0C);
    drive(0, 0, 1, 0, 0, 0, 'h0D, 'h20);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 0, 0, 'h30, 'h00);
    drive(0, 1, 0, 0, 0, 0, 'h30, 'h00);
    drive(0, 0, 0, 0, 0, 0, 'h00, 'h00);
    drive(1, 0, 0, 0, 0, 0, 'h00, 'h00);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 0, 0, 0, 4 * i + 1, 'h10 + i);
    drive(0, 0, 1, 0, 0, 0, 'h20, 'h2A);
    drive(0, 0, 0, 0, 1, 0, 'h00, 'h33);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 0, 0, 'h00, 'h00);
    drive(0, 0, 0, 0, 0, 0, 'h00, 'h00);
    drive(1, 0, 0, 0, 0, 0, 'h00, 'h00);
    drive(0, 0, 1, 0, 0, 0, 'h02, 'h11);
    drive(0, 0, 1, 0, 0, 0, 'h12, 'h21);
    drive(0, 1, 1, 1, 1, 1, 'h22, 'h05);
    drive(1, 0, 1, 0, 0, 0, 'h06, 'h07);
    drive(0, 0, 0, 0, 0, 0, 'h00, 'h00);

    // Randomized traffic with all opcode combinations and occasional reset
    for (int i = 0; i < 600; i++) begin
      u = int'($urandom_range(0, 59));
      drive(u == 0,
            $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 35,
            $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 30,
            $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
    end

    @(posedge clk);
    #1;
    reset = 0; is_ret = 0; is_call = 0; is_jz = 0; is_jmp = 0;
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries not consumed", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jump_ctrl.md
JUMP_CTRL -- requirements
Module: jump_ctrl

Interface
REQ-001 Parameter PC_COUNT_WIDTH, default 6, width of program-counter values.
REQ-002 Parameter STACK_DEPTH, default 4, return-address stack entries; must be a power of two and at least 2.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pc_count  input  PC_COUNT_WIDTH  current instruction address from the program counter.
REQ-006 is_jmp  input  1  decoded unconditional jump.
REQ-007 is_jz  input  1  decoded jump-if-accumulator-zero.
REQ-008 is_call  input  1  decoded call (jump, push return address).
REQ-009 is_ret  input  1  decoded return (jump to popped address).
REQ-010 target  input  PC_COUNT_WIDTH  jump/call destination from the instruction.
REQ-011 acc_zero  input  1  accumulator equals zero.
REQ-012 jump_enable  output  1  load jump_value into the PC at the next posedge.
REQ-013 jump_value  output  PC_COUNT_WIDTH  next PC when jump_enable is 1.
REQ-014 sp  output  clog2(STACK_DEPTH)+1  current stack occupancy, 0..STACK_DEPTH.
REQ-015 stack_empty / stack_full  output  1 each  sp==0 / sp==STACK_DEPTH.
REQ-016 fault  output  1  sticky stack error flag (see Configuration).

Function
REQ-017 jump_enable and jump_value shall be combinational from the current inputs and registered stack state; the PC consumes them at the same posedge as the instruction completes (zero added latency).
REQ-018 Decode priority when several opcode inputs are high: is_ret > is_call > is_jz > is_jmp; lower-priority inputs are ignored.
REQ-019 is_jmp: jump_enable=1, jump_value=target.
REQ-020 is_jz: jump_enable=acc_zero, jump_value=target.
REQ-021 is_call with stack not full: jump_enable=1, jump_value=target; at posedge, push (pc_count+1) mod 2^PC_COUNT_WIDTH and increment sp.
REQ-022 is_ret with stack not empty: jump_enable=1, jump_value=top entry; at posedge, decrement sp.
REQ-023 No opcode asserted: jump_enable=0, jump_value=0, stack unchanged.
REQ-024 Stack is LIFO; entries at or above sp are don't-care but shall not be read out as jump_value.
REQ-025 Overflow (is_call while full) and underflow (is_ret while empty) behaviour as in Configuration.

Reset
REQ-026 While reset=1 at posedge: sp=0, fault=0, all stack entries cleared to 0; reset overrides any simultaneous call/ret.
REQ-027 Reset mid-program discards all pending return addresses; stack_empty=1 and stack_full=0 in the cycle after reset.
REQ-028 jump_enable remains a pure function of the inputs during reset; the PC's own reset dominates it.

Configuration
REQ-029 Macro JUMP_CTRL_FAULT_EN selects the error policy.
REQ-030 Defined: overflow call yields jump_enable=0, no push, and fault set at the posedge; underflow ret yields jump_enable=0, sp stays 0, and fault set; once fault=1, jump_enable is forced 0 and the stack is frozen until reset.
REQ-031 Undefined: fault tied 0; overflow call jumps and overwrites the oldest entry (circular, sp stays STACK_DEPTH); underflow ret yields jump_enable=0, no state change.

Verification
REQ-032 Reset, then is_jmp with target=0x15 -> jump_enable=1, jump_value=0x15, sp=0.
REQ-033 is_jz with target=0x08: acc_zero=0 -> jump_enable=0; acc_zero=1 -> jump_enable=1, jump_value=0x08.
REQ-034 pc_count=0x3F, is_call target=0x10 -> jump_value=0x10, sp 0->1; then is_ret -> jump_value=0x00 (wrap), sp=0.
REQ-035 Four nested calls at pc 0x01,0x05,0x09,0x0D -> stack_full=1; four rets -> jump_value 0x0E,0x0A,0x06,0x02, then stack_empty=1.
REQ-036 Fifth call while full: with JUMP_CTRL_FAULT_EN -> jump_enable=0, fault=1, a following is_jmp gives jump_enable=0; without it -> jump_enable=1, fault=0, subsequent rets return the newest four addresses.
REQ-037 is_call and is_ret both high with sp=2 -> ret wins, sp=1; reset asserted together with is_call -> sp=0 next cycle.
